// File: rtl/vga_frame_reader.sv
// 160x120x3 framebuffer with a one-pixel-per-clock write port, a self-timed clear,
// and 640x480@60Hz scan-out with 4x replication driven from a 25 MHz tick.
module vga_frame_reader #(
    parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
    parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120,
    parameter logic [2:0] BACKGROUND      = 3'b000,
    parameter int         H_VISIBLE       = 640,
    parameter int         H_FRONT         = 16,
    parameter int         H_SYNC          = 96,
    parameter int         H_BACK          = 48,
    parameter int         V_VISIBLE       = 480,
    parameter int         V_FRONT         = 10,
    parameter int         V_SYNC          = 2,
    parameter int         V_BACK          = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       write_dropped,
    output logic       vblank_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);

    localparam logic [9:0]  H_VIS_L   = 10'(H_VISIBLE);
    localparam logic [9:0]  H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  HS_FIRST  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]  HS_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0]  V_VIS_L   = 10'(V_VISIBLE);
    localparam logic [9:0]  V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0]  VS_FIRST  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]  VS_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]  VBL_LINE  = 10'(V_VISIBLE - 1);
    localparam int          MEM_DEPTH = int'(X_SCREEN_PIXELS) * int'(Y_SCREEN_PIXELS);
    localparam logic [14:0] CLR_LAST  = 15'(MEM_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // y*160 + x without a multiplier: (y<<7) + (y<<5) + x
    function automatic logic [14:0] pix_addr(input logic [6:0] row, input logic [7:0] col);
        return {1'b0, row, 7'b0000000} + {3'b000, row, 5'b00000} + {7'b0000000, col};
    endfunction

    logic [2:0]  fb_mem [0:MEM_DEPTH-1];

    state_t      state_q, state_d;
    logic [14:0] clr_addr_q, clr_addr_d;
    logic        phase_q, phase_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [14:0] rd_addr_q, rd_addr_d;
    logic [2:0]  rd_data_q;
    logic        hs_p1_q, hs_p1_d;
    logic        vs_p1_q, vs_p1_d;
    logic        vis_p1_q, vis_p1_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic [2:0]  rgb_q, rgb_d;
    logic        vblank_q, vblank_d;
    logic        drop_q, drop_d;

    logic        tick_s;
    logic        vis_s;
    logic        hs_s;
    logic        vs_s;
    logic        wr_ok_s;
    logic [14:0] wr_addr_s;
    logic        clear_busy_s;
    logic        clr_we_s;

    // Clear FSM next-state and clear-address sequencing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = 15'd0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 15'd0;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = 15'd0;
            end
        endcase
    end

    // Clear FSM outputs.
    always_comb begin
        clear_busy_s = 1'b0;
        clr_we_s     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_busy_s = 1'b1;
                clr_we_s     = 1'b1;
            end
            ST_IDLE: begin
                clear_busy_s = 1'b0;
                clr_we_s     = 1'b0;
            end
            default: begin
                clear_busy_s = 1'b0;
                clr_we_s     = 1'b0;
            end
        endcase
    end

    // Write-port qualification; anything not written while plotting is reported as dropped.
    always_comb begin
        wr_ok_s   = plot && (x < X_SCREEN_PIXELS) && (y < Y_SCREEN_PIXELS) && (state_q == ST_IDLE);
        wr_addr_s = pix_addr(y, x);
        drop_d    = plot && !wr_ok_s;
    end

    // Pixel tick, raster counters and the two-tick scan-out pipeline.
    always_comb begin
        tick_s    = phase_q;
        phase_d   = ~phase_q;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        rd_addr_d = rd_addr_q;
        hs_p1_d   = hs_p1_q;
        vs_p1_d   = vs_p1_q;
        vis_p1_d  = vis_p1_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;

        vis_s    = (h_cnt_q < H_VIS_L) && (v_cnt_q < V_VIS_L);
        hs_s     = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_s     = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        vblank_d = tick_s && (h_cnt_q == H_LAST) && (v_cnt_q == VBL_LINE);

        if (tick_s) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = 10'd0;
                end else begin
                    v_cnt_d = v_cnt_q + 10'd1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // Off-screen positions read address 0 so the index never leaves the array.
            if (vis_s) begin
                rd_addr_d = pix_addr(v_cnt_q[8:2], h_cnt_q[9:2]);
            end else begin
                rd_addr_d = 15'd0;
            end
            hs_p1_d   = hs_s;
            vs_p1_d   = vs_s;
            vis_p1_d  = vis_s;
            hs_d      = hs_p1_q;
            vs_d      = vs_p1_q;
            blank_n_d = vis_p1_q;
            if (vis_p1_q) begin
                rgb_d = rd_data_q;
            end else begin
                rgb_d = 3'b000;
            end
        end else begin
            h_cnt_d = h_cnt_q;
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= 15'd0;
            phase_q    <= 1'b0;
            h_cnt_q    <= 10'd0;
            v_cnt_q    <= 10'd0;
            rd_addr_q  <= 15'd0;
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            vis_p1_q   <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            blank_n_q  <= 1'b0;
            rgb_q      <= 3'b000;
            vblank_q   <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            phase_q    <= phase_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            rd_addr_q  <= rd_addr_d;
            hs_p1_q    <= hs_p1_d;
            vs_p1_q    <= vs_p1_d;
            vis_p1_q   <= vis_p1_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            blank_n_q  <= blank_n_d;
            rgb_q      <= rgb_d;
            vblank_q   <= vblank_d;
            drop_q     <= drop_d;
        end
    end

    // Framebuffer: one write and one registered read per clk; a same-edge read sees old data.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            fb_mem[clr_addr_q] <= BACKGROUND;
        end else if (wr_ok_s) begin
            fb_mem[wr_addr_s] <= colour;
        end
        rd_data_q <= fb_mem[rd_addr_q];
    end

    assign clear_busy    = clear_busy_s;
    assign write_dropped = drop_q;
    assign vblank_start  = vblank_q;
    assign vga_r         = {8{rgb_q[2]}};
    assign vga_g         = {8{rgb_q[1]}};
    assign vga_b         = {8{rgb_q[0]}};
    assign vga_hs        = hs_q;
    assign vga_vs        = vs_q;
    assign vga_blank_n   = blank_n_q;
    assign vga_sync_n    = 1'b0;
    assign vga_clk       = phase_q;

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Consumer end of the pixel-write interface the game FSMs drive (x, y, colour, plot).
- Holds a 160x120x3-bit framebuffer, accepts one pixel write per clock, and scans the buffer out as 640x480@60Hz VGA with 4x pixel replication.
- Provides a self-timed full-screen clear and a vblank pulse so upstream movers can pace redraws to frame boundaries.
- Sits between the game datapaths and the board DAC pins.

Parameters:
X_SCREEN_PIXELS, 8'd160, framebuffer width
Y_SCREEN_PIXELS, 7'd120, framebuffer height
BACKGROUND, 3'b000, colour written by clear
H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixel ticks
V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high
x  in  8  write column
y  in  7  write row
colour  in  3  {R,G,B} write data
plot  in  1  write strobe, one pixel per clk
clear_req  in  1  start full-buffer clear (level sampled in IDLE)
clear_busy  out  1  high while clearing
write_dropped  out  1  1-clk pulse: a plot was discarded
vblank_start  out  1  1-clk pulse at first tick of line 480
vga_r, vga_g, vga_b  out  8 each  colour to DAC
vga_hs, vga_vs  out  1  syncs, active low
vga_blank_n  out  1  low outside visible area
vga_sync_n  out  1  tied 0
vga_clk  out  1  25 MHz pixel clock (tick phase)

Behaviour:
- Reset (async, any time): h_cnt=0, v_cnt=0, tick phase=0, FSM=IDLE, clear counter=0; vga_hs=vga_vs=1, vga_blank_n=0, rgb=0, vga_clk=0, clear_busy=0, write_dropped=0, vblank_start=0. Framebuffer contents are not altered by reset.
- Pixel tick: the phase register toggles every clk; tick=1 on alternate clks; vga_clk mirrors phase.
- Counters advance on tick: h_cnt 0..799 wraps to 0 and increments v_cnt; v_cnt 0..524 wraps to 0.
- Line period: 1600 clks. Frame period: 840000 clks.
- Address: addr = y*160 + x, computed as (y<<7)+(y<<5)+x; 15 bits, range 0..19199.
- Write port:
  - If plot && x<160 && y<120 && FSM==IDLE: mem[addr] <= colour on the same edge.
  - Otherwise, if plot: no write, and write_dropped=1 on the next clk.
- Read port:
  - Read address = (v_cnt>>2)*160 + (h_cnt>>2).
  - Memory read is synchronous; the address and the read data are each registered.
  - Pipeline latency: 2 ticks (4 clks) from counter value to pins.
  - hs, vs and visible are delayed by the same 2 ticks so all outputs align.
- Same-address read and write in one clk: the read returns old data. New data is visible on the next scan of that pixel.
- Syncs, evaluated on undelayed counters:
  - vga_hs=0 for h_cnt in 656..751.
  - vga_vs=0 for v_cnt in 490..491.
  - visible = h_cnt<640 && v_cnt<480.
- Colour output: each colour bit expands to 8'hFF or 8'h00 (R=colour[2], G=colour[1], B=colour[0]). rgb is forced to 0 and vga_blank_n=0 when not visible.
- vblank_start: 1-clk pulse on the tick where v_cnt becomes 480 and h_cnt=0 (undelayed).
- Clear FSM:
  - IDLE: clear_req=1 -> CLEAR, clr_addr=0, clear_busy=1 on the next clk.
  - CLEAR: writes BACKGROUND to mem[clr_addr] every clk, clr_addr+1. After writing 19199 -> IDLE, clear_busy=0. Duration is 19200 clks.
  - clear_req while in CLEAR is ignored; no restart.
  - plot during CLEAR is dropped and pulses write_dropped.
  - Scan-out continues during CLEAR.
  - Reset mid-clear -> IDLE; the buffer is left partially cleared.
- Boundary values: x=159, y=119 is legal (addr 19199). x=160 or y=120 is dropped. x=255 is dropped, with no aliasing into another row.

Test Plan:
1. Reset, then run 2 frames -> hs low for exactly 192 clks every 1600 clks; vs low for exactly 3200 clks every 840000 clks; vga_clk period 2 clks; vblank_start pulses once per frame.
2. plot (x=0,y=0,colour=3'b100) -> during the next frame, screen pixels h 0..3, v 0..3 show r=8'hFF, g=b=0; pixel h=4 shows BACKGROUND.
3. plot (159,119,3'b011) -> screen h 636..639, v 476..479 show r=0, g=b=8'hFF; blank_n=0 at h=640.
4. plot (160,5,3'b111) and plot (5,120,3'b111) -> write_dropped pulses twice; a full-frame scan shows no change versus a golden buffer.
5. Fill the buffer with 3'b111, pulse clear_req -> clear_busy high for 19200 clks; a plot during CLEAR is dropped; the next full frame is all 0.
6. Assert reset mid-line (h_cnt=300) and mid-clear, then release -> counters restart at 0, FSM IDLE, clear_busy=0; pixels written before reset are still displayed.
